// File: rtl/uart_rx_deser_if.sv
// RX byte-buffer write port: one-cycle strobe, window address, zero-extended data,
// plus the buffer's full flag travelling back to the deserializer.
interface uart_rx_deser_if;
  logic        buf_write_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        rx_buffer_full_i;

  modport master (
    output buf_write_o,
    output addr_o,
    output wdata_o,
    input  rx_buffer_full_i
  );

  modport slave (
    input  buf_write_o,
    input  addr_o,
    input  wdata_o,
    output rx_buffer_full_i
  );
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer: oversamples rx_i, recovers LSB-first bytes and
// pushes each good byte into the RX buffer, with sticky framing/overrun flags.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low
// ST_START | timing to start-bit mid-point, reject glitches
// ST_DATA  | sampling 8 data bits at bit mid-points
// ST_STOP  | sampling stop bit; write, overrun or framing error
// ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx_deser #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BUF_ADDR     = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               rx_i,
  input  logic               err_clr_i,
  uart_rx_deser_if.master    bus,
  output logic               busy_o,
  output logic               frame_err_o,
  output logic               overrun_o
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_m;
  logic        rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      cnt             <= 16'd0;
      bit_idx         <= 3'd0;
      shreg           <= 8'd0;
      bus.buf_write_o <= 1'b0;
      bus.addr_o      <= 32'd0;
      bus.wdata_o     <= 32'd0;
      busy_o          <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      bus.buf_write_o <= 1'b0;
      bus.addr_o      <= 32'd0;

      // Clear first so a same-cycle set below takes priority.
      if (err_clr_i) begin
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state  <= ST_START;
            cnt    <= 16'd0;
            busy_o <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= 16'd0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              if (!bus.rx_buffer_full_i) begin
                bus.buf_write_o <= 1'b1;
                bus.addr_o      <= BUF_ADDR;
                bus.wdata_o     <= {24'd0, shreg};
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              state       <= ST_BREAK;
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
